barrel_shifter: RTL and testbench
=================================

Name: barrel_shifter

Overview:
8-bit registered barrel shifter with parallel load and a recirculating shift mode.
- Logical-shifts an 8-bit word left or right by 0-7 positions in one clock.
- In load mode it shifts the external input; otherwise it shifts its own registered output.
- Used as a datapath utility block feeding downstream logic from a single registered output.

Parameters:
- WIDTH, 8, data width. Fixed at 8 for this block; the shift amount is log2(WIDTH) = 3 bits.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RS  input  1  reset; asynchronous, active-high.
- in  input  8  parallel data input.
- p_load  input  1  1 = shift the value on `in`; 0 = shift the current `out` (recirculate).
- shift_l_r  input  1  direction; 0 = left (toward MSB), 1 = right (toward LSB).
- shift_by  input  3  shift amount, 0-7.
- out  output  8  registered shifted result.

Behaviour:
- Reset:
  - RS=1 forces `out` to 8'h00 immediately, without waiting for a clock edge.
  - `out` stays 0 while RS is held high; RS dominates all other inputs.
  - Reset asserted mid-operation discards the current value. The first rising CK after RS falls performs a normal update.
- Source select at each rising CK (RS=0):
  - src = p_load ? in : out.
  - out <= SHIFT(src, shift_by, shift_l_r).
- SHIFT function:
  - Logical shift with zero fill; no rotation and no sign extension.
  - Left by n: result = src << n; the low n bits become 0 and bits shifted past bit 7 are lost.
  - Right by n: result = src >> n; the high n bits become 0.
  - shift_by=0: result = src (pass-through, load or hold).
  - shift_by=7: only one source bit survives. Left keeps src[0] in bit 7; right keeps src[7] in bit 0.
- Structure: three cascaded mux stages (shift by 1, 2, 4) selected by shift_by[0], shift_by[1], shift_by[2], applied per direction. Purely combinational ahead of the single 8-bit output register.
- Latency: exactly one CK edge from inputs to `out`. Inputs are sampled only at the rising edge, and changes between edges have no effect.
- Recirculate mode (p_load=0):
  - Each edge shifts the previous `out` again by the current shift_by and direction.
  - Repeated shifting drains to 8'h00.
  - p_load=0 with shift_by=0 holds `out`.
- Simultaneous events:
  - p_load, shift_l_r and shift_by changing on the same edge are all sampled together.
  - A direction change in recirculate mode applies to the current `out` on that edge.
- No overflow or carry flags, and no X propagation on defined inputs.

Test Plan:
- Reset: RS=1 with in=8'h5A, p_load=1 -> out=8'h00 asynchronously, without a clock edge. Release RS, then one edge with shift_by=0, left -> out=8'h5A.
- Load-left sweep: in=8'h5A, p_load=1, shift_l_r=0, shift_by=0..7, one edge each -> out=5A, B4, 68, D0, A0, 40, 80, 00.
- Load-right sweep: in=8'h5A, p_load=1, shift_l_r=1, shift_by=0..7 -> out=5A, 2D, 16, 0B, 05, 02, 01, 00.
- Recirculate: load 8'h5A (shift_by=0), then p_load=0, left, shift_by=1 for 4 edges -> B4, 68, D0, A0. Then shift_by=0 -> holds A0.
- Mid-operation reset: during recirculate with out=8'h68, pulse RS between edges -> out=8'h00 immediately. The next edge with p_load=0 keeps out=00.
- Boundary: in=8'h81, p_load=1, shift_by=7 -> left gives 8'h80, right gives 8'h01.

Source files
------------

// File: rtl/barrel_shifter.sv
// 8-bit registered logical barrel shifter: load or recirculate, shift left/right by 0-7.
// Three cascaded 1/2/4 mux stages per direction feed a single output register.
module barrel_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             RS,
  input  logic [WIDTH-1:0] in,
  input  logic             p_load,
  input  logic             shift_l_r,
  input  logic [2:0]       shift_by,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] l1, l2, l4;
  logic [WIDTH-1:0] r1, r2, r4;

  always_comb begin
    src = p_load ? in : out_q;

    // Zero-fill on both sides; bits pushed past either end are dropped.
    l1 = shift_by[0] ? {src[WIDTH-2:0], 1'b0}  : src;
    l2 = shift_by[1] ? {l1[WIDTH-3:0], 2'b00}  : l1;
    l4 = shift_by[2] ? {l2[WIDTH-5:0], 4'h0}   : l2;

    r1 = shift_by[0] ? {1'b0, src[WIDTH-1:1]}  : src;
    r2 = shift_by[1] ? {2'b00, r1[WIDTH-1:2]}  : r1;
    r4 = shift_by[2] ? {4'h0, r2[WIDTH-1:4]}   : r2;

    out_d = shift_l_r ? r4 : l4;
  end

  always_ff @(posedge CK or posedge RS) begin
    if (RS) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed sweeps, reset cases and random
// traffic compared against an arithmetic reference model.
module tb_barrel_shifter;

  logic       CK = 1'b0;
  logic       RS = 1'b0;
  logic [7:0] in = 8'h00;
  logic       p_load = 1'b0;
  logic       shift_l_r = 1'b0;
  logic [2:0] shift_by = 3'd0;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;
  int model = 0;

  barrel_shifter dut (
    .CK(CK), .RS(RS), .in(in), .p_load(p_load),
    .shift_l_r(shift_l_r), .shift_by(shift_by), .out(out)
  );

  // Clock / reset block
  initial forever #5 CK = ~CK;

  // Reference: shifting is multiply/divide by a power of two, kept to 8 bits.
  function automatic int ref_shift(int src, bit dir, int n);
    if (dir) return src / (1 << n);
    return (src * (1 << n)) % 256;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of inputs, advance the model, check the registered output.
  task automatic step(bit p, bit dir, int n, logic [7:0] data, string tag);
    int src;
    @(negedge CK);
    p_load = p;
    shift_l_r = dir;
    shift_by = 3'(n);
    in = data;
    @(posedge CK);
    src = p ? int'(data) : model;
    model = ref_shift(src, dir, n);
    #1;
    check(tag, out, 8'(model));
  endtask

  logic [7:0] left_tbl [8] = '{8'h5A, 8'hB4, 8'h68, 8'hD0, 8'hA0, 8'h40, 8'h80, 8'h00};
  logic [7:0] right_tbl[8] = '{8'h5A, 8'h2D, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};
  logic [7:0] recirc_tbl[4] = '{8'hB4, 8'h68, 8'hD0, 8'hA0};

  initial begin
    // Asynchronous reset before any clock edge
    in = 8'h5A;
    p_load = 1'b1;
    #2 RS = 1'b1;
    #1 check("reset_async", out, 8'h00);
    repeat (3) @(posedge CK);
    #1 check("reset_held", out, 8'h00);
    @(negedge CK);
    RS = 1'b0;
    model = 0;
    step(1'b1, 1'b0, 0, 8'h5A, "reset_release_load");
    check("reset_release_const", out, 8'h5A);

    // Load sweeps in both directions
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, i, 8'h5A, "load_left");
      check("load_left_tbl", out, left_tbl[i]);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, i, 8'h5A, "load_right");
      check("load_right_tbl", out, right_tbl[i]);
    end

    // Recirculate left by 1, then hold
    step(1'b1, 1'b0, 0, 8'h5A, "recirc_load");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1, 8'hFF, "recirc_left");
      check("recirc_tbl", out, recirc_tbl[i]);
    end
    step(1'b0, 1'b0, 0, 8'hFF, "recirc_hold");
    check("recirc_hold_const", out, 8'hA0);

    // Inputs changing between edges must not disturb the output
    @(negedge CK);
    in = 8'h33;
    p_load = 1'b1;
    shift_by = 3'd3;
    #2 check("between_edges", out, 8'hA0);

    // Mid-operation reset while out = 68
    step(1'b1, 1'b0, 0, 8'h5A, "mid_load");
    step(1'b0, 1'b0, 1, 8'h00, "mid_shift1");
    step(1'b0, 1'b0, 1, 8'h00, "mid_shift2");
    check("mid_pre_reset", out, 8'h68);
    @(negedge CK);
    #2 RS = 1'b1;
    #1 check("mid_reset_async", out, 8'h00);
    RS = 1'b0;
    model = 0;
    step(1'b0, 1'b0, 1, 8'hFF, "mid_after_reset");
    check("mid_after_reset_const", out, 8'h00);

    // Boundary: shift by 7
    step(1'b1, 1'b0, 7, 8'h81, "bound_left7");
    check("bound_left7_const", out, 8'h80);
    step(1'b1, 1'b1, 7, 8'h81, "bound_right7");
    check("bound_right7_const", out, 8'h01);

    // Direction change in recirculate mode applies to the current value
    step(1'b1, 1'b0, 0, 8'h3C, "dir_load");
    step(1'b0, 1'b0, 2, 8'h00, "dir_left2");
    step(1'b0, 1'b1, 3, 8'h00, "dir_right3");

    // Randomized traffic; load is weighted so recirculation does not drain at once
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7), 8'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
